rt6_inv: RTL and testbench

- Inverse round transform for the RT6 state update; used on the decryption/verification side to roll a 768-bit state back one round.
- Given the post-round state S, the message block M2 and the key Z0, it recovers the pre-round state T6, so that the forward RT6 applied to the result reproduces S.
- It sequences one shared inverse-AES core (aes_128_inv) twice: first keyed with Z0, then keyless.

---
 rtl/rt6_inv.sv | 230 +++++++++++++++++++++++
 tb/tb_rt6_inv.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt6_inv.sv
// rt6_inv: inverse RT6 round. Rolls a 768-bit post-round state S back one
// round to the pre-round state T6, given the message block M2 and key Z0:
//   T6[0:127]   = AESinv_Z0(S[128:255])
//   T6[640:767] = AESinv_keyless(S[0:127] ^ T6[0:127] ^ M2)
//   T6[128:639] = S[256:767]
// A single inverse AES round core is shared and used twice in sequence.
//
// Ports:
//   clk     in   1    rising-edge clock
//   rst     in   1    synchronous reset, active-high
//   start   in   1    one-cycle request, sampled only when idle
//   S_in    in   768  post-round state, bit 0 = MSB
//   M2      in   128  message block of the forward round
//   Z0      in   128  round key
//   busy    out  1    round in progress
//   done    out  1    one-cycle pulse, T6_out valid
//   T6_out  out  768  recovered pre-round state
//
// aes_128_inv: one inverse AES round, AddRoundKey -> InvMixColumns ->
// InvShiftRows -> InvSubBytes. While rst is high the round of din is loaded;
// the result appears on dout LAT cycles after that load cycle.
module aes_128_inv #(
    parameter int LAT = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         keyless,
    input  logic [0:127] din,
    input  logic [0:127] key,
    output logic [0:127] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, x);
        end
        return r;
    endfunction

    // Undo the S-box affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return ginv(a);
    endfunction

    // Byte i of a block is bits [8i +: 8]; state position (row r, col c) = 4c + r.
    function automatic logic [0:127] inv_round(input logic [0:127] x);
        logic [7:0]   a [16];
        logic [7:0]   m [16];
        logic [0:127] y;
        for (int i = 0; i < 16; i++) a[i] = x[8*i +: 8];
        for (int c = 0; c < 4; c++) begin
            m[4*c+0] = gmul(8'h0e, a[4*c]) ^ gmul(8'h0b, a[4*c+1]) ^ gmul(8'h0d, a[4*c+2]) ^ gmul(8'h09, a[4*c+3]);
            m[4*c+1] = gmul(8'h09, a[4*c]) ^ gmul(8'h0e, a[4*c+1]) ^ gmul(8'h0b, a[4*c+2]) ^ gmul(8'h0d, a[4*c+3]);
            m[4*c+2] = gmul(8'h0d, a[4*c]) ^ gmul(8'h09, a[4*c+1]) ^ gmul(8'h0e, a[4*c+2]) ^ gmul(8'h0b, a[4*c+3]);
            m[4*c+3] = gmul(8'h0b, a[4*c]) ^ gmul(8'h0d, a[4*c+1]) ^ gmul(8'h09, a[4*c+2]) ^ gmul(8'h0e, a[4*c+3]);
        end
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[8*(4*c+r) +: 8] = inv_sbox(m[4*(((c - r) + 4) % 4) + r]);
            end
        end
        return y;
    endfunction

    logic [0:127] pipe_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            // load stage: key mix and full inverse round
            pipe_q[0] <= inv_round(din ^ (keyless ? 128'd0 : key));
            for (int i = 1; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            // delay stages: the loaded result walks towards dout once
            pipe_q[0] <= '0;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[LAT-1];
endmodule

module rt6_inv #(
    parameter int AES_LAT = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:767] S_in,
    input  logic [0:127] M2,
    input  logic [0:127] Z0,
    output logic         busy,
    output logic         done,
    output logic [0:767] T6_out
);
    localparam int CW = (AES_LAT > 1) ? $clog2(AES_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(AES_LAT - 1);

    typedef enum logic [2:0] {IDLE, LOAD1, WAIT1, LOAD2, WAIT2, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:767]  s_q, s_d;
    logic [0:127]  m2_q, m2_d;
    logic [0:127]  z0_q, z0_d;
    logic [0:767]  t6_q, t6_d;

    logic          core_rst;
    logic          core_keyless;
    logic [0:127]  core_in;
    logic [0:127]  core_key;
    logic [0:127]  core_out;

    aes_128_inv #(.LAT(AES_LAT)) u_core (
        .clk     (clk),
        .rst     (core_rst),
        .keyless (core_keyless),
        .din     (core_in),
        .key     (core_key),
        .dout    (core_out)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        s_d          = s_q;
        m2_d         = m2_q;
        z0_d         = z0_q;
        t6_d         = t6_q;
        core_rst     = 1'b0;
        core_keyless = 1'b0;
        core_in      = '0;
        core_key     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d     = S_in;
                    m2_d    = M2;
                    z0_d    = Z0;
                    state_d = LOAD1;
                end
            end
            LOAD1: begin
                core_rst = 1'b1;
                core_in  = s_q[128:255];
                core_key = z0_q;
                cnt_d    = '0;
                state_d  = WAIT1;
            end
            WAIT1: begin
                if (cnt_q == CNT_LAST) begin
                    t6_d[0:127] = core_out;
                    cnt_d       = '0;
                    state_d     = LOAD2;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOAD2: begin
                // needs the first half-result captured at the end of WAIT1
                core_rst     = 1'b1;
                core_keyless = 1'b1;
                core_in      = s_q[0:127] ^ t6_q[0:127] ^ m2_q;
                cnt_d        = '0;
                state_d      = WAIT2;
            end
            WAIT2: begin
                if (cnt_q == CNT_LAST) begin
                    t6_d[640:767] = core_out;
                    t6_d[128:639] = s_q[256:767];
                    cnt_d         = '0;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Reset holds the core in its load state with a zero, keyed input.
        if (rst) begin
            core_rst     = 1'b1;
            core_keyless = 1'b0;
            core_in      = '0;
            core_key     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            m2_q    <= '0;
            z0_q    <= '0;
            t6_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            m2_q    <= m2_d;
            z0_q    <= z0_d;
            t6_q    <= t6_d;
        end
    end

    assign busy   = (state_q == LOAD1) || (state_q == WAIT1) ||
                    (state_q == LOAD2) || (state_q == WAIT2);
    assign done   = (state_q == ST_DONE);
    assign T6_out = t6_q;
endmodule

// File: tb/tb_rt6_inv.sv
// tb_rt6_inv: scoreboard bench for rt6_inv. Expected T6 values are produced
// by a table-driven AES reference (forward S-box built from field inverses,
// inverse S-box by inverting that table, InvMixColumns as MixColumns cubed);
// most rounds start from a known T6 and run the forward RT6 to make S.
module tb_rt6_inv;
    localparam int AES_LAT = 5;
    localparam int DONE_C  = 2*AES_LAT + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:767] S_in;
    logic [0:127] M2;
    logic [0:127] Z0;
    logic         busy;
    logic         done;
    logic [0:767] T6_out;

    always #5 clk = ~clk;

    rt6_inv #(.AES_LAT(AES_LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .S_in   (S_in),
        .M2     (M2),
        .Z0     (Z0),
        .busy   (busy),
        .done   (done),
        .T6_out (T6_out)
    );

    int           n_tests  = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    logic [0:767] exp_q[$];
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w = {v, v};
        return w[15-n -: 8];
    endfunction

    function automatic logic [0:127] mixcol(input logic [0:127] x);
        logic [0:127] y;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[32*c +: 8]; a1 = x[32*c+8 +: 8]; a2 = x[32*c+16 +: 8]; a3 = x[32*c+24 +: 8];
            y[32*c    +: 8] = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
            y[32*c+8  +: 8] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
            y[32*c+16 +: 8] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
            y[32*c+24 +: 8] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
        end
        return y;
    endfunction

    function automatic logic [0:127] aes_fwd(input logic [0:127] x, input logic [0:127] k);
        logic [0:127] t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[8*(4*c+r) +: 8] = sbox[x[8*(4*((c+r)%4)+r) +: 8]];
        return mixcol(t) ^ k;
    endfunction

    function automatic logic [0:127] aes_inv(input logic [0:127] y, input logic [0:127] k);
        logic [0:127] z;
        logic [0:127] x;
        z = mixcol(mixcol(mixcol(y ^ k)));
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                x[8*(4*c+r) +: 8] = isbox[z[8*(4*((c-r+4)%4)+r) +: 8]];
        return x;
    endfunction

    function automatic logic [0:767] rt6_fwd(input logic [0:767] t, input logic [0:127] m, input logic [0:127] z);
        logic [0:767] s;
        s[128:255] = aes_fwd(t[0:127], z);
        s[0:127]   = aes_fwd(t[640:767], 128'd0) ^ t[0:127] ^ m;
        s[256:767] = t[128:639];
        return s;
    endfunction

    function automatic logic [0:767] rt6_ref_inv(input logic [0:767] s, input logic [0:127] m, input logic [0:127] z);
        logic [0:767] t;
        t[0:127]   = aes_inv(s[128:255], z);
        t[640:767] = aes_inv(s[0:127] ^ t[0:127] ^ m, 128'd0);
        t[128:639] = s[256:767];
        return t;
    endfunction

    function automatic logic [0:767] rand768();
        logic [0:767] v;
        for (int w = 0; w < 24; w++) v[32*w +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [0:127] rand128();
        logic [0:127] v;
        for (int w = 0; w < 4; w++) v[32*w +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got done=1 expected no pending request");
            end else begin
                chk("t6_at_done", T6_out, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one cycle; returns in cycle 1 of the round.
    task automatic issue(input logic [0:767] s, input logic [0:127] m, input logic [0:127] z, input logic [0:767] e);
        S_in  = s;
        M2    = m;
        Z0    = z;
        start = 1'b1;
        exp_q.push_back(e);
        step();
        start = 1'b0;
        S_in  = rand768();
        M2    = rand128();
        Z0    = rand128();
    endtask

    // Full round with per-cycle busy/done checks; returns in cycle DONE_C+1.
    task automatic round(input string tag, input logic [0:767] s, input logic [0:127] m, input logic [0:127] z, input logic [0:767] e);
        issue(s, m, z, e);
        for (int c = 1; c <= DONE_C; c++) begin
            chk($sformatf("%s_busy_c%0d", tag, c), busy, (c < DONE_C));
            chk($sformatf("%s_done_c%0d", tag, c), done, (c == DONE_C));
            step();
        end
    endtask

    initial begin
        logic [0:767] t6, s, e, sa, sb;
        logic [0:127] m, z, ma, za;
        int           d0;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x]  = b;
            isbox[b] = 8'(x);
        end

        rst = 1'b1; start = 1'b0; S_in = '0; M2 = '0; Z0 = '0;
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_t6", T6_out, 768'd0);
        rst = 1'b0;
        step();

        // Round-trip on the reference vector, then hold check.
        for (int i = 0; i < 96; i++) t6[8*i +: 8] = 8'(i % 48);
        m = 128'h0123456789abcdeffedcba9876543210;
        z = 128'h428a2f98d728ae227137449123ef65cd;
        round("rt", rt6_fwd(t6, m, z), m, z, t6);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("hold_t6_%0d", k), T6_out, t6);
            chk($sformatf("hold_done_%0d", k), done, 1'b0);
            step();
        end

        // Passthrough of the copied middle section.
        s = '0;
        s[256:767] = {512{1'b1}};
        round("pass", s, 128'd0, 128'd0, rt6_ref_inv(s, 128'd0, 128'd0));
        chk("pass_mid", T6_out[128:639], {512{1'b1}});

        // Starts during WAIT1 and during DONE must be ignored.
        t6 = rand768(); ma = rand128(); za = rand128();
        sa = rt6_fwd(t6, ma, za);
        d0 = done_cnt;
        issue(sa, ma, za, t6);
        for (int c = 1; c <= DONE_C + 6; c++) begin
            start = (c == 4) || (c == DONE_C);
            if (start) begin
                sb   = rand768();
                S_in = sb;
                M2   = rand128();
                Z0   = rand128();
            end
            chk($sformatf("ign_busy_c%0d", c), busy, (c < DONE_C));
            step();
        end
        start = 1'b0;
        chk("ign_one_done", done_cnt - d0, 1);
        chk("ign_t6", T6_out, t6);

        // Reset in cycle 7 aborts the round.
        d0 = done_cnt;
        t6 = rand768(); m = rand128(); z = rand128();
        issue(rt6_fwd(t6, m, z), m, z, t6);
        for (int c = 1; c < 7; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_t6", T6_out, 768'd0);
        chk("abort_no_done", done_cnt - d0, 0);

        // start together with rst is dropped.
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", busy, 1'b0);
        step();
        chk("rst_start_busy2", busy, 1'b0);

        t6 = rand768(); m = rand128(); z = rand128();
        round("fresh", rt6_fwd(t6, m, z), m, z, t6);

        // Back-to-back: second start in the cycle right after done.
        t6 = rand768(); m = rand128(); z = rand128();
        round("b2b_a", rt6_fwd(t6, m, z), m, z, t6);
        t6 = rand768(); m = rand128(); z = rand128();
        round("b2b_b", rt6_fwd(t6, m, z), m, z, t6);

        // Randomized rounds, some against the inverse reference directly.
        for (int r = 0; r < 6; r++) begin
            m = rand128(); z = rand128();
            if (r % 2 == 0) begin
                t6 = rand768();
                round($sformatf("rnd%0d", r), rt6_fwd(t6, m, z), m, z, t6);
            end else begin
                s = rand768();
                e = rt6_ref_inv(s, m, z);
                round($sformatf("rnd%0d", r), s, m, z, e);
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        step(); step();
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
